mc_sram_arbiter: RTL and testbench
==================================

Name: mc_sram_arbiter

Overview:
- Arbitrates one single-port synchronous register SRAM between the MCU memory-controller bus and NUM_REQ internal FPGA peripheral engines.
- Sits between the SB_IO tristate pad wrapper (mc_din/mc_dout/mc_data_oe) and the SRAM array.
- Sequences every access as read or write, drives the pad output enable, and round-robins the internal requesters.
- MCU has priority because its bus timing is fixed.

Parameters:
- MC_DATA_WIDTH, 16, data width of MCU bus and SRAM.
- MC_ADD_WIDTH, 6, SRAM address width.
- NUM_REQ, 2, number of internal requesters (1..4).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- mc_ce, mc_oe, mc_we  in  1 each  MCU strobes, active low, already synchronised to clock.
- mc_add  in  MC_ADD_WIDTH  MCU address.
- mc_din  in  MC_DATA_WIDTH  data from pads.
- mc_dout  out  MC_DATA_WIDTH  read data to pads.
- mc_data_oe  out  1  pad output enable.
- req  in  NUM_REQ  internal request, level, held until gnt.
- req_we  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_add  in  NUM_REQ*MC_ADD_WIDTH  packed addresses; requester i at [i*W +: W].
- req_wdata  in  NUM_REQ*MC_DATA_WIDTH  packed write data.
- gnt  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  out  MC_DATA_WIDTH  internal read data, valid in the gnt cycle.
- ram_en, ram_we  out  1  SRAM strobes.
- ram_add  out  MC_ADD_WIDTH  SRAM address.
- ram_wdata  out  MC_DATA_WIDTH  SRAM write data.
- ram_rdata  in  MC_DATA_WIDTH  SRAM read data, 1 cycle after ram_en.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0.
  - All outputs 0: mc_dout, mc_data_oe, gnt, rdata, ram_* = 0.
  - A RAM write issued before reset is not retracted.
- MCU access request: mc_ce=0 and exactly one of mc_we/mc_oe low.
  - Write: mc_we=0, mc_oe=1. Read: mc_we=1, mc_oe=0.
  - Both low or both high: no access; mc_data_oe forced 0.
- States: IDLE, MC_ISSUE, MC_HOLD, INT_ISSUE, INT_DONE.
- IDLE:
  - MCU request present: ram_en=1, ram_we=~mc_we, ram_add=mc_add, ram_wdata=mc_din; go MC_ISSUE.
  - Otherwise, any req: pick the first set bit scanning from rr_ptr upward with wrap; drive the RAM from that requester; go INT_ISSUE.
  - MCU and internal request in the same cycle: MCU wins.
- MC_ISSUE (1 cycle): ram_en=0.
  - Read: mc_dout<=ram_rdata, mc_data_oe<=1.
  - Go MC_HOLD.
- MC_HOLD:
  - Stay while mc_ce=0; mc_data_oe stays 1 only while the read strobe is still valid.
  - Exactly one SRAM access per CE-low window.
  - mc_ce=1: mc_data_oe<=0, go IDLE.
- INT_ISSUE (1 cycle): ram_en=0; go INT_DONE.
- INT_DONE (1 cycle):
  - gnt[i]=1; rdata=ram_rdata for reads, rdata unchanged for writes.
  - rr_ptr=(i+1) mod NUM_REQ; go IDLE.
  - req[i] sampled in the gnt cycle is ignored. Requester deasserts req after gnt or holds it to queue a new access.
- Latency:
  - Internal: gnt 2 cycles after acceptance in IDLE.
  - MCU read: mc_data_oe high 2 cycles after strobe sampled.
  - Worst case with an internal op in flight: 4 cycles. MCU bus read timing must allow this.
- MCU strobes arriving during INT_*: the internal op completes, then the MCU is serviced from IDLE.
- mc_data_oe is never 1 outside a valid MCU read. No bus contention after mc_ce rises: at most 1 cycle.

Optional Feature:
- Macro: MC_SRAM_ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit counter counts consecutive MCU accesses completed while any req is pending.
  - At count 4, the next IDLE cycle grants the internal requester even if an MCU request is present.
  - Counter clears on any internal grant or when no req is pending.
- Not defined: strict MCU priority; the counter is not instantiated.

Test Plan:
- Reset mid-read:
  - Stimulus: MCU read of addr 0x05 (contents 0xA5A5); reset pulsed in MC_ISSUE.
  - Response: mc_data_oe=0, mc_dout=0 asynchronously; state IDLE afterwards.
- MCU write/read:
  - Stimulus: MCU writes 0x1234 to addr 0x0A, then reads addr 0x0A.
  - Response: mc_dout=0x1234; mc_data_oe=1 two cycles after strobe; 0 the cycle after mc_ce=1.
- Internal round-robin:
  - Stimulus: req=2'b11 held, both reads, addr 0x01 and 0x02.
  - Response: gnt order 01,10,01,10; gnt 2 cycles after each IDLE acceptance; rdata matches SRAM.
- Collision:
  - Stimulus: MCU read and req[0] asserted in the same IDLE cycle.
  - Response: MCU serviced first; gnt[0] only after mc_ce rises.
- Illegal strobe:
  - Stimulus: mc_ce=0, mc_we=0, mc_oe=0 for 5 cycles.
  - Response: no ram_en, mc_data_oe=0; internal req still granted.
- Fairness (macro defined):
  - Stimulus: 6 back-to-back MCU writes with req[1] pending.
  - Response: gnt[1] pulses after the 4th MCU access; the 5th MCU access is delayed by 3 cycles.

Source files
------------

// File: rtl/mc_sram_arbiter.sv
// Single-port SRAM arbiter: the MCU bus has priority, internal engines share the rest round-robin.
// Optional MC_SRAM_ARB_FAIRNESS_EN forces an internal grant after four MCU accesses while a request waits.
module mc_sram_arbiter #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int NUM_REQ       = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             mc_ce,
  input  logic                             mc_oe,
  input  logic                             mc_we,
  input  logic [MC_ADD_WIDTH-1:0]          mc_add,
  input  logic [MC_DATA_WIDTH-1:0]         mc_din,
  output logic [MC_DATA_WIDTH-1:0]         mc_dout,
  output logic                             mc_data_oe,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*MC_ADD_WIDTH-1:0]  req_add,
  input  logic [NUM_REQ*MC_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [MC_DATA_WIDTH-1:0]         rdata,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [MC_ADD_WIDTH-1:0]          ram_add,
  output logic [MC_DATA_WIDTH-1:0]         ram_wdata,
  input  logic [MC_DATA_WIDTH-1:0]         ram_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MC_ISSUE, S_MC_HOLD, S_INT_ISSUE, S_INT_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic [PTR_W-1:0]         r_rr_ptr, r_sel, w_pick;
  logic                     r_mc_rd, r_int_rd, r_oe;
  logic [MC_DATA_WIDTH-1:0] r_dout, r_rdata;
  logic [NUM_REQ-1:0]       r_gnt, w_sel_oh;
  logic                     w_any_req, w_mc_wr, w_mc_rd, w_mc_acc, w_fair_force;
  logic                     w_take_mc, w_take_int;
  logic                     w_ram_en, w_ram_we;
  logic [MC_ADD_WIDTH-1:0]  w_ram_add;
  logic [MC_DATA_WIDTH-1:0] w_ram_wdata;

  // First set request bit at or above ptr, wrapping around.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && r[idx]) begin
        sel   = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_any_req = |req;
  assign w_mc_wr   = ~mc_ce & ~mc_we &  mc_oe;
  assign w_mc_rd   = ~mc_ce &  mc_we & ~mc_oe;
  assign w_mc_acc  = w_mc_wr | w_mc_rd;
  assign w_pick    = rr_pick(req, r_rr_ptr);

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) w_sel_oh[i] = (int'(r_sel) == i);
  end

`ifdef MC_SRAM_ARB_FAIRNESS_EN
  logic [2:0] r_fair_cnt;

  // Counts MCU completions that happened while an internal request was starving.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fair_cnt <= '0;
    end else if (!w_any_req || r_state == S_INT_DONE) begin
      r_fair_cnt <= '0;
    end else if (r_state == S_MC_HOLD && mc_ce && r_fair_cnt < 3'd4) begin
      r_fair_cnt <= r_fair_cnt + 3'd1;
    end
  end

  assign w_fair_force = (r_fair_cnt == 3'd4) && w_any_req;
`else
  assign w_fair_force = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // RAM strobes are combinational in IDLE so the SRAM captures on the accepting edge.
  always_comb begin
    w_next      = r_state;
    w_take_mc   = 1'b0;
    w_take_int  = 1'b0;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_add   = '0;
    w_ram_wdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (!reset) begin
          if (w_mc_acc && !w_fair_force) begin
            w_take_mc   = 1'b1;
            w_ram_en    = 1'b1;
            w_ram_we    = ~mc_we;
            w_ram_add   = mc_add;
            w_ram_wdata = mc_din;
            w_next      = S_MC_ISSUE;
          end else if (w_any_req) begin
            w_take_int  = 1'b1;
            w_ram_en    = 1'b1;
            w_ram_we    = req_we[w_pick];
            w_ram_add   = req_add[int'(w_pick)*MC_ADD_WIDTH +: MC_ADD_WIDTH];
            w_ram_wdata = req_wdata[int'(w_pick)*MC_DATA_WIDTH +: MC_DATA_WIDTH];
            w_next      = S_INT_ISSUE;
          end
        end
      end
      S_MC_ISSUE:  w_next = S_MC_HOLD;
      S_MC_HOLD:   if (mc_ce) w_next = S_IDLE;
      S_INT_ISSUE: w_next = S_INT_DONE;
      S_INT_DONE:  w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_sel    <= '0;
      r_mc_rd  <= 1'b0;
      r_int_rd <= 1'b0;
      r_oe     <= 1'b0;
      r_dout   <= '0;
      r_gnt    <= '0;
      r_rdata  <= '0;
    end else begin
      r_gnt <= '0;
      if (w_take_mc) r_mc_rd <= w_mc_rd;
      if (w_take_int) begin
        r_sel    <= w_pick;
        r_int_rd <= ~req_we[w_pick];
      end
      unique case (r_state)
        S_MC_ISSUE: begin
          if (r_mc_rd) r_dout <= ram_rdata;
          r_oe <= r_mc_rd & w_mc_rd;
        end
        // Pad drive drops as soon as the read strobe is no longer valid.
        S_MC_HOLD:   r_oe <= r_oe & w_mc_rd;
        S_INT_ISSUE: begin
          r_gnt <= w_sel_oh;
          if (r_int_rd) r_rdata <= ram_rdata;
        end
        S_INT_DONE: begin
          if (int'(r_sel) >= NUM_REQ - 1) r_rr_ptr <= '0;
          else                            r_rr_ptr <= r_sel + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mc_dout    = r_dout;
  assign mc_data_oe = r_oe;
  assign gnt        = r_gnt;
  assign rdata      = r_rdata;
  assign ram_en     = w_ram_en;
  assign ram_we     = w_ram_we;
  assign ram_add    = w_ram_add;
  assign ram_wdata  = w_ram_wdata;

endmodule

// File: tb/tb_mc_sram_arbiter.sv
// Directed bench for mc_sram_arbiter with a registered SRAM model and grant/read scoreboards.
module tb_mc_sram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        mc_ce, mc_oe, mc_we;
  logic [5:0]  mc_add;
  logic [15:0] mc_din, mc_dout;
  logic        mc_data_oe;
  logic [1:0]  req, req_we, gnt;
  logic [11:0] req_add;
  logic [31:0] req_wdata;
  logic [15:0] rdata;
  logic        ram_en, ram_we;
  logic [5:0]  ram_add;
  logic [15:0] ram_wdata, ram_rdata;

  logic        ld_en;
  logic [5:0]  ld_add;
  logic [15:0] ld_data;
  logic [15:0] mem [0:63];
  int          n_ram_acc = 0;

  typedef struct packed {
    logic [1:0]  g;
    logic [15:0] d;
  } gexp_t;

  gexp_t       gq[$];
  logic [15:0] mq[$];
  int          n_chk = 0, n_pass = 0, n_fail = 0, n_gnt_seen = 0;
  logic        prev_oe = 1'b0;

  always #5 clock = ~clock;

  mc_sram_arbiter #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6), .NUM_REQ(2)) dut (
    .clock(clock), .reset(reset),
    .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we), .mc_add(mc_add),
    .mc_din(mc_din), .mc_dout(mc_dout), .mc_data_oe(mc_data_oe),
    .req(req), .req_we(req_we), .req_add(req_add), .req_wdata(req_wdata),
    .gnt(gnt), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_add(ram_add),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clock) begin
    if (ld_en) begin
      mem[ld_add] <= ld_data;
    end else if (ram_en) begin
      n_ram_acc <= n_ram_acc + 1;
      if (ram_we) mem[ram_add] <= ram_wdata;
      else        ram_rdata    <= mem[ram_add];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and score any grant pulse or rising pad enable.
  task automatic tick();
    gexp_t e;
    @(posedge clock);
    #1;
    if (gnt !== 2'b00) begin
      n_gnt_seen++;
      if (gq.size() == 0) check("unexpected_gnt", {30'd0, gnt}, 32'd0);
      else begin
        e = gq.pop_front();
        check("gnt_id", {30'd0, gnt}, {30'd0, e.g});
        check("gnt_rdata", {16'd0, rdata}, {16'd0, e.d});
      end
    end
    if (mc_data_oe === 1'b1 && prev_oe === 1'b0) begin
      if (mq.size() == 0) check("unexpected_oe", 32'd1, 32'd0);
      else check("mc_dout", {16'd0, mc_dout}, {16'd0, mq.pop_front()});
    end
    prev_oe = mc_data_oe;
  endtask

  task automatic wait_gnt(input string tag, input int maxc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (gnt === 2'b00 && cyc < maxc);
    check(tag, {31'd0, (gnt !== 2'b00)}, 32'd1);
  endtask

  task automatic mc_write(input logic [5:0] a, input logic [15:0] d, input int lowc);
    mc_ce = 1'b0; mc_we = 1'b0; mc_oe = 1'b1; mc_add = a; mc_din = d;
    repeat (lowc) tick();
    mc_ce = 1'b1; mc_we = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, acc0, gs0;
    logic [1:0] eg;
    reset = 1'b1; mc_ce = 1'b1; mc_oe = 1'b1; mc_we = 1'b1; mc_add = '0; mc_din = '0;
    req = '0; req_we = '0; req_add = '0; req_wdata = '0;
    ld_en = 1'b1; ld_add = 6'h01; ld_data = 16'h1111;
    @(posedge clock); #1; ld_add = 6'h02; ld_data = 16'h2222;
    @(posedge clock); #1; ld_add = 6'h05; ld_data = 16'hA5A5;
    @(posedge clock); #1; ld_en = 1'b0; req = 2'b01;
    #1;
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_oe", {31'd0, mc_data_oe}, 32'd0);
    check("rst_dout", {16'd0, mc_dout}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    req = 2'b00;
    tick();
    reset = 1'b0;

    // MCU write then read of 0x0A
    acc0 = n_ram_acc;
    mc_ce = 1'b0; mc_we = 1'b0; mc_oe = 1'b1; mc_add = 6'h0A; mc_din = 16'h1234;
    #1;
    check("wr_ram_en", {31'd0, ram_en}, 32'd1);
    check("wr_ram_we", {31'd0, ram_we}, 32'd1);
    check("wr_ram_add", {26'd0, ram_add}, 32'h0A);
    check("wr_ram_wdata", {16'd0, ram_wdata}, 32'h1234);
    repeat (4) tick();
    mc_ce = 1'b1; mc_we = 1'b1;
    tick();
    check("wr_one_access", n_ram_acc - acc0, 32'd1);
    check("wr_mem", {16'd0, mem[6'h0A]}, 32'h1234);

    acc0 = n_ram_acc;
    mq.push_back(16'h1234);
    mc_ce = 1'b0; mc_we = 1'b1; mc_oe = 1'b0; mc_add = 6'h0A;
    #1;
    check("rd_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    check("rd_oe_early", {31'd0, mc_data_oe}, 32'd0);
    tick();
    check("rd_oe_lat", {31'd0, mc_data_oe}, 32'd1);
    tick(); tick();
    check("rd_oe_hold", {31'd0, mc_data_oe}, 32'd1);
    mc_ce = 1'b1; mc_oe = 1'b1;
    tick();
    check("rd_oe_release", {31'd0, mc_data_oe}, 32'd0);
    check("rd_one_access", n_ram_acc - acc0, 32'd1);

    // Reset pulsed while a read of 0x05 sits in MC_ISSUE
    mc_ce = 1'b0; mc_we = 1'b1; mc_oe = 1'b0; mc_add = 6'h05;
    tick();
    #2 reset = 1'b1;
    #1;
    check("arst_oe", {31'd0, mc_data_oe}, 32'd0);
    check("arst_dout", {16'd0, mc_dout}, 32'd0);
    mc_ce = 1'b1; mc_oe = 1'b1;
    tick();
    reset = 1'b0;

    // Round-robin between two held readers
    req_we = 2'b00; req_add = {6'h02, 6'h01}; req = 2'b11;
    gq.push_back('{g: 2'b01, d: 16'h1111});
    gq.push_back('{g: 2'b10, d: 16'h2222});
    gq.push_back('{g: 2'b01, d: 16'h1111});
    gq.push_back('{g: 2'b10, d: 16'h2222});
    #1;
    check("rr_ram_en", {31'd0, ram_en}, 32'd1);
    check("rr_ram_add", {26'd0, ram_add}, 32'h01);
    for (int i = 1; i <= 11; i++) begin
      tick();
      eg = (i % 3 != 2) ? 2'b00 : ((i == 2 || i == 8) ? 2'b01 : 2'b10);
      check("rr_gnt_timing", {30'd0, gnt}, {30'd0, eg});
    end
    req = 2'b00;
    tick();
    check("rr_idle_ram_en", {31'd0, ram_en}, 32'd0);

    // MCU read collides with req[0]
    mq.push_back(16'h1111);
    gq.push_back('{g: 2'b01, d: 16'h2222});
    mc_ce = 1'b0; mc_we = 1'b1; mc_oe = 1'b0; mc_add = 6'h01;
    req_add = {6'h02, 6'h02}; req = 2'b01;
    #1;
    check("col_ram_add", {26'd0, ram_add}, 32'h01);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("col_no_gnt", {30'd0, gnt}, 32'd0);
    end
    mc_ce = 1'b1; mc_oe = 1'b1;
    wait_gnt("col_gnt_tmo", 8, cyc);
    check("col_gnt_lat", cyc, 32'd3);
    req = 2'b00;
    tick();

    // Both strobes low is not an access; internal traffic still flows
    mc_ce = 1'b0; mc_we = 1'b0; mc_oe = 1'b0;
    #1;
    check("ill_ram_en0", {31'd0, ram_en}, 32'd0);
    tick();
    check("ill_ram_en1", {31'd0, ram_en}, 32'd0);
    check("ill_oe1", {31'd0, mc_data_oe}, 32'd0);
    tick();
    req_add = {6'h05, 6'h02}; req = 2'b10;
    gq.push_back('{g: 2'b10, d: 16'hA5A5});
    #1;
    check("ill_int_add", {26'd0, ram_add}, 32'h05);
    wait_gnt("ill_gnt_tmo", 6, cyc);
    check("ill_gnt_lat", cyc, 32'd2);
    req = 2'b00;
    tick();
    check("ill_oe2", {31'd0, mc_data_oe}, 32'd0);
    mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
    tick();

    // Internal write leaves rdata alone; held req queues a read-back
    req_we = 2'b01; req_add = {6'h00, 6'h10}; req_wdata = {16'h0000, 16'hBEEF}; req = 2'b01;
    gq.push_back('{g: 2'b01, d: 16'hA5A5});
    #1;
    check("iw_ram_we", {31'd0, ram_we}, 32'd1);
    check("iw_ram_wdata", {16'd0, ram_wdata}, 32'hBEEF);
    wait_gnt("iw_gnt_tmo", 6, cyc);
    check("iw_gnt_lat", cyc, 32'd2);
    req_we = 2'b00;
    gq.push_back('{g: 2'b01, d: 16'hBEEF});
    wait_gnt("ir_gnt_tmo", 6, cyc);
    check("ir_gnt_lat", cyc, 32'd3);
    req = 2'b00;
    tick();

`ifdef MC_SRAM_ARB_FAIRNESS_EN
    // Six back-to-back MCU writes against a starving req[1]
    gs0 = n_gnt_seen;
    req_we = 2'b00; req_add = {6'h02, 6'h00}; req = 2'b10;
    gq.push_back('{g: 2'b10, d: 16'h2222});
    for (int w = 0; w < 6; w++) begin
      mc_write(6'(6'h20 + w), 16'(16'hC000 + w), 6);
      if (w == 3) check("fair_before", n_gnt_seen - gs0, 32'd0);
      if (w == 4) check("fair_after5", n_gnt_seen - gs0, 32'd1);
    end
    req = 2'b00;
    tick();
    check("fair_gnt_count", n_gnt_seen - gs0, 32'd1);
    check("fair_mem5", {16'd0, mem[6'h24]}, 32'hC004);
    check("fair_mem6", {16'd0, mem[6'h25]}, 32'hC005);
`else
    gs0 = n_gnt_seen;
    mc_write(6'h20, 16'hC000, 4);
    check("strict_no_gnt", n_gnt_seen - gs0, 32'd0);
    check("strict_mem", {16'd0, mem[6'h20]}, 32'hC000);
`endif

    check("gq_empty", gq.size(), 32'd0);
    check("mq_empty", mq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
